// File: rtl/rd_pkg.sv
// Shared destination-register definitions for the scoreboard and the rd_in UVC.
package rd_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int MAX_PEND_DEF   = 3;
    localparam int REG_ADDR_W_DEF = $clog2(NUM_REGS_DEF);

    typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rd_pend_counter.sv
// Per-register outstanding-write counter; saturates at MAX_PEND and at zero.
module rd_pend_counter #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic nonzero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full    = (cnt_q == CNT_W'(MAX_PEND));
    assign nonzero = |cnt_q;

    // A simultaneous inc and dec cancel, leaving the count as it was.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rd_scoreboard.sv
// Destination-register scoreboard: tracks pending writes per rd, answers
// decode-stage busy queries and raises stall.
module rd_scoreboard
    import rd_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int REG_ADDR_W = $clog2(NUM_REGS),
    parameter int NUM_SRC    = 2,
    parameter int MAX_PEND   = MAX_PEND_DEF,
    parameter int CNT_W      = $clog2(MAX_PEND + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    output logic                          issue_ready,
    input  logic                          wb_valid,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rs,
    output logic [NUM_SRC-1:0]            src_busy,
    output logic                          stall,
    output logic [REG_ADDR_W+CNT_W-1:0]   pend_total,
    output logic                          err_underflow
);

    localparam int PT_W = REG_ADDR_W + CNT_W;

    // Out-of-range addresses alias to x0 so they never touch a counter.
    function automatic logic [REG_ADDR_W-1:0] eff_addr(input logic [REG_ADDR_W-1:0] a);
        if (32'(a) < NUM_REGS) begin
            return a;
        end
        return '0;
    endfunction

    logic [REG_ADDR_W-1:0] ird;
    logic [REG_ADDR_W-1:0] wrd;
    logic [NUM_REGS-1:0]   full_v;
    logic [NUM_REGS-1:0]   nz_v;
    logic                  issue_acc;
    logic                  wb_acc;
    logic                  wb_under;
    logic [PT_W-1:0]       pend_total_q;
    logic [PT_W-1:0]       pend_total_d;
    logic                  err_q;
    logic                  err_d;

    assign ird = eff_addr(issue_rd);
    assign wrd = eff_addr(wb_rd);

    assign full_v[0] = 1'b0;
    assign nz_v[0]   = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        rd_pend_counter #(
            .MAX_PEND (MAX_PEND),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (issue_acc && (ird == REG_ADDR_W'(g))),
            .dec     (wb_acc && (wrd == REG_ADDR_W'(g))),
            .clr     (flush),
            .full    (full_v[g]),
            .nonzero (nz_v[g])
        );
    end

    // A same-rd writeback frees a slot in the cycle it arrives.
    assign issue_ready = !(full_v[ird] && !(wb_valid && (wrd == ird)));
    assign issue_acc   = issue_valid && issue_ready && (ird != '0);
    assign wb_acc      = wb_valid && (wrd != '0) && nz_v[wrd];
    assign wb_under    = wb_valid && (wrd != '0) && !nz_v[wrd];

    always_comb begin
        src_busy = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_busy[i] = nz_v[eff_addr(src_rs[i*REG_ADDR_W +: REG_ADDR_W])];
        end
    end

    assign stall = (|src_busy) || (issue_valid && !issue_ready);

    always_comb begin
        pend_total_d = pend_total_q;
        if (flush) begin
            pend_total_d = '0;
        end else begin
            pend_total_d = pend_total_q + PT_W'(issue_acc) - PT_W'(wb_acc);
        end
    end

    // Underflow is sticky across flush; only reset clears it.
    assign err_d = err_q || wb_under;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_total_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pend_total_q <= pend_total_d;
            err_q        <= err_d;
        end
    end

    assign pend_total    = pend_total_q;
    assign err_underflow = err_q;

endmodule
